// File: rtl/alu_exec_if.sv
// Request/response bundle between the ALU control decoder side and the execution unit.
// The unit itself connects through the slave modport; the driver side uses master.
interface alu_exec_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        ALU_control;
  logic [DATA_W-1:0] operand_a;
  logic [DATA_W-1:0] operand_b;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result;
  logic              zero;
  logic              invalid_op;
  logic              busy;

  modport master (
    output in_valid, ALU_control, operand_a, operand_b, out_ready,
    input  in_ready, out_valid, result, zero, invalid_op, busy
  );

  modport slave (
    input  in_valid, ALU_control, operand_a, operand_b, out_ready,
    output in_ready, out_valid, result, zero, invalid_op, busy
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execution unit: single-cycle ALU ops plus an iterative shift-add MUL that stalls upstream.
// Results sit in a one-deep output register with valid/ready backpressure.
module alu_exec_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_exec_if.slave  bus
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] res_q;
  logic              zero_q, inv_q, ovld_q, busy_q;
  logic              in_ready, accept, mul_done;
  logic [DATA_W:0]   alu_out;

  // Returns {invalid, result}; MUL falls to default here but never uses this path.
  function automatic logic [DATA_W:0] alu_eval(input logic [3:0] code,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] sa, sb;
    logic [DATA_W-1:0]        r;
    logic                     bad;
    sa  = $signed(a);
    sb  = $signed(b);
    r   = '0;
    bad = 1'b0;
    case (code)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_SLT:  r = {{(DATA_W-1){1'b0}}, (sa < sb)};
      OP_NOR:  r = ~(a | b);
      default: bad = 1'b1;
    endcase
    return {bad, r};
  endfunction

  assign in_ready = (state_q == S_IDLE) && (!ovld_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign alu_out  = alu_eval(bus.ALU_control, bus.operand_a, bus.operand_b);

  always_comb begin
    mcand_d  = mcand_q << 1;
    mplier_d = mplier_q >> 1;
    acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    cnt_d    = cnt_q + CNT_W'(1);
    mul_done = (state_q == S_MUL) && (cnt_d == CNT_W'(DATA_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      res_q    <= '0;
      zero_q   <= 1'b0;
      inv_q    <= 1'b0;
      ovld_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      if (ovld_q && bus.out_ready) ovld_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (bus.ALU_control == OP_MUL) begin
              mcand_q  <= bus.operand_a;
              mplier_q <= bus.operand_b;
              acc_q    <= '0;
              cnt_q    <= '0;
              busy_q   <= 1'b1;
              state_q  <= S_MUL;
            end else begin
              res_q  <= alu_out[DATA_W-1:0];
              zero_q <= (alu_out[DATA_W-1:0] == '0);
              inv_q  <= alu_out[DATA_W];
              ovld_q <= 1'b1;
            end
          end
        end
        S_MUL: begin
          mcand_q  <= mcand_d;
          mplier_q <= mplier_d;
          acc_q    <= acc_d;
          cnt_q    <= cnt_d;
          // The output slot is already free here: entry required it to be drained.
          if (mul_done) begin
            res_q   <= acc_d;
            zero_q  <= (acc_d == '0);
            inv_q   <= 1'b0;
            ovld_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = ovld_q;
  assign bus.result     = res_q;
  assign bus.zero       = zero_q;
  assign bus.invalid_op = inv_q;
  assign bus.busy       = busy_q;

endmodule
